adrv9001_rx_sched: RTL and testbench
====================================

# adrv9001_rx_sched

Timed receive scheduler for one ADRV9001 receive channel. Software queues commands of the form {start timestamp, sample count}. The block keeps a free-running sample timestamp and, at each command's start time, asserts the channel's receive enable. It counts valid received samples, then deasserts enable and marks the last sample. It sits in the `dclk_div` domain, between the AXI command path and the receive channel's enable input and data output.

## Interface
- `CMD_DEPTH`, default 4: command FIFO depth; power of two, 2..16.
- `TS_WIDTH`, default 32: timestamp and sample-count width.
- `clk` in 1: single clock; connected to `dclk_div`.
- `rst` in 1: synchronous, active-high reset.
- `s_cmd_tdata` in 2*TS_WIDTH: {start_time, num_samples}; start_time occupies the upper half.
- `s_cmd_tvalid` in 1: command valid.
- `s_cmd_tready` out 1: command FIFO not full.
- `sample_ce` in 1: one pulse per sample period; advances the timestamp.
- `rx_valid` in 1: received-sample valid from the channel datapath.
- `abort` in 1: stops the active command and flushes the queue.
- `rx_enable` out 1: receive enable to the channel.
- `rx_last` out 1: single-cycle pulse coincident with the final counted `rx_valid`.
- `timestamp` out TS_WIDTH: current sample time.
- `busy` out 1: 1 whenever state is not IDLE.
- `cmd_done` out 1: pulse when a command completes.
- `cmd_late` out 1: pulse when a command is dropped as late.
- `late_cnt` out 16: count of late commands; saturates at 16'hFFFF.
- `fifo_level` out $clog2(CMD_DEPTH)+1: number of queued commands.

## Operation
- Timestamp:
  - `timestamp` increments by 1 on each cycle with `sample_ce`=1.
  - Wraps modulo 2^TS_WIDTH.
  - Never stops and is not affected by `abort`.
- Command FIFO:
  - A push occurs when `s_cmd_tvalid` and `s_cmd_tready` are both 1.
  - A pop occurs on the IDLE→WAIT transition.
  - Push and pop in the same cycle are allowed; `fifo_level` is then unchanged.
- State IDLE:
  - `rx_enable`=0.
  - If the FIFO is non-empty, pop the head into `start_r` and `count_r`, then go to WAIT.
- State WAIT, evaluated every cycle:
  - Compute diff = start_r − timestamp, taken modulo 2^TS_WIDTH and read as signed.
  - diff negative (MSB=1): pulse `cmd_late`, increment `late_cnt`, go to IDLE.
  - diff == 0: go to ACTIVE with `rx_enable`=1 from the next cycle.
  - Otherwise stay in WAIT.
  - The scheduling window is therefore up to 2^(TS_WIDTH−1)−1 samples ahead.
- State ACTIVE:
  - `rx_enable`=1.
  - `rx_cnt` counts `rx_valid` pulses, starting from 0.
  - When `rx_valid` arrives with `rx_cnt`==count_r−1, pulse `rx_last` in that same cycle.
  - On the following cycle: `rx_enable`=0, pulse `cmd_done`, go to IDLE.
  - count_r==0 means continuous: stay in ACTIVE until `abort`; `rx_last` never asserts.
- Abort (highest priority, checked in any state):
  - Next cycle: `rx_enable`=0 and state=IDLE.
  - The FIFO is emptied and any push in the same cycle is discarded.
  - No `cmd_done` or `rx_last` is generated.
- The next command may enter WAIT one cycle after the previous command's `cmd_done`.

## Timing
- Reset values: `rx_enable`=0, `rx_last`=0, `cmd_done`=0, `cmd_late`=0, `busy`=0, `timestamp`=0, `late_cnt`=0, `fifo_level`=0, `s_cmd_tready`=1, state=IDLE.
- All outputs are registered. `s_cmd_tready` is registered as level<CMD_DEPTH.
- Push-to-WAIT latency: a command pushed into an empty FIFO in cycle N is in WAIT at N+2 (N+1 for the FIFO write, N+2 for the pop).
- Enable latency: `rx_enable` rises exactly 1 cycle after the first cycle in WAIT with `timestamp`==start_r.
- Disable latency: `rx_enable` falls 1 cycle after the `rx_last` cycle.
- Reset mid-operation: everything returns to reset values on the next edge, including `timestamp`.
- `rx_valid` is ignored outside ACTIVE.

## Test plan
- Push {100, 8} at `timestamp`=0, with `sample_ce` every cycle and `rx_valid` every 2 cycles. Required:
  - `rx_enable` rises the cycle after `timestamp`=100.
  - `rx_last` pulses on the 8th `rx_valid`.
  - `cmd_done` and `rx_enable`=0 follow one cycle later.
- Push {50, 4} while `timestamp`=60. Required: `cmd_late`=1 for one cycle, `late_cnt`=1, `rx_enable` stays 0.
- Push 4 commands back-to-back with CMD_DEPTH=4, plus a 5th while the first is in WAIT. Required:
  - `s_cmd_tready`=0 while `fifo_level`=4.
  - All commands then execute in order.
- Preload `timestamp`≈0xFFFF_FFF0 and push start=0x0000_0005. Required: enable asserts after the wrap, at `timestamp`=5, with no late flag.
- Push {10, 0} (continuous), then `abort` 100 cycles later while 2 commands are queued. Required:
  - `rx_enable`=0 next cycle.
  - `fifo_level`=0, no `rx_last`, no `cmd_done`.
- Assert `rst` during ACTIVE. Required: all outputs return to reset values next cycle, with `s_cmd_tready`=1.

Source files
------------

// File: rtl/adrv9001_rx_sched.sv
// Timed receive scheduler for one ADRV9001 rx channel.
// Queued {start, count} commands gate rx_enable against a sample clock.
module adrv9001_rx_sched #(
  parameter int CMD_DEPTH = 4,
  parameter int TS_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*TS_WIDTH-1:0]         s_cmd_tdata,
  input  logic                          s_cmd_tvalid,
  output logic                          s_cmd_tready,
  input  logic                          sample_ce,
  input  logic                          rx_valid,
  input  logic                          abort,
  output logic                          rx_enable,
  output logic                          rx_last,
  output logic [TS_WIDTH-1:0]           timestamp,
  output logic                          busy,
  output logic                          cmd_done,
  output logic                          cmd_late,
  output logic [15:0]                   late_cnt,
  output logic [$clog2(CMD_DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACTIVE,
    DONE
  } state_t;

  state_t state;

  logic [2*TS_WIDTH-1:0] mem [CMD_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_nxt;
  logic                  push;
  logic                  pop;
  logic [TS_WIDTH-1:0]   start_r;
  logic [TS_WIDTH-1:0]   count_r;
  logic [TS_WIDTH-1:0]   rx_cnt;
  logic [TS_WIDTH-1:0]   diff;

  assign push = s_cmd_tvalid && s_cmd_tready && !abort;
  assign pop  = (state == IDLE) && (fifo_level != '0) && !abort;
  // Modular distance to start; MSB set means the start time has passed.
  assign diff = start_r - timestamp;

  always_comb begin
    level_nxt = fifo_level;
    unique case (1'b1)
      push && !pop: level_nxt = fifo_level + LW'(1);
      pop && !push: level_nxt = fifo_level - LW'(1);
      default:      level_nxt = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_cmd_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      s_cmd_tready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level   <= level_nxt;
      s_cmd_tready <= level_nxt < LW'(CMD_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            timestamp <= '0;
    else if (sample_ce) timestamp <= timestamp + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rx_enable <= 1'b0;
      rx_last   <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_late  <= 1'b0;
      late_cnt  <= '0;
      start_r   <= '0;
      count_r   <= '0;
      rx_cnt    <= '0;
    end else begin
      rx_last  <= 1'b0;
      cmd_done <= 1'b0;
      cmd_late <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        rx_enable <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pop) begin
              {start_r, count_r} <= mem[rd_ptr];
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (diff[TS_WIDTH-1]) begin
              cmd_late <= 1'b1;
              if (late_cnt != 16'hFFFF) late_cnt <= late_cnt + 16'd1;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (diff == '0) begin
              state     <= ACTIVE;
              rx_enable <= 1'b1;
              rx_cnt    <= '0;
            end
          end
          ACTIVE: begin
            // count_r == 0 runs until abort
            if (rx_valid) begin
              if (count_r != '0 &&
                  rx_cnt == count_r - TS_WIDTH'(1)) begin
                rx_last <= 1'b1;
                state   <= DONE;
              end else begin
                rx_cnt <= rx_cnt + TS_WIDTH'(1);
              end
            end
          end
          DONE: begin
            rx_enable <= 1'b0;
            cmd_done  <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adrv9001_rx_sched.sv
// Directed bench for adrv9001_rx_sched.
// A second 8-bit-timestamp instance exercises the wrap case.
module tb_adrv9001_rx_sched;

  logic        clk;
  logic        rst;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        sample_ce;
  logic        rx_valid;
  logic        abort;
  logic        rx_enable;
  logic        rx_last;
  logic [31:0] timestamp;
  logic        busy;
  logic        cmd_done;
  logic        cmd_late;
  logic [15:0] late_cnt;
  logic [2:0]  fifo_level;

  logic [15:0] tdata8;
  logic        tvalid8;
  logic        tready8;
  logic        rx_enable8;
  logic        rx_last8;
  logic [7:0]  ts8;
  logic        busy8;
  logic        done8;
  logic        late8;
  logic [15:0] late_cnt8;
  logic [2:0]  level8;

  int checks = 0;
  int errors = 0;

  adrv9001_rx_sched #(.CMD_DEPTH(4), .TS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_tdata(tdata), .s_cmd_tvalid(tvalid),
    .s_cmd_tready(tready),
    .sample_ce(sample_ce), .rx_valid(rx_valid),
    .abort(abort),
    .rx_enable(rx_enable), .rx_last(rx_last),
    .timestamp(timestamp), .busy(busy),
    .cmd_done(cmd_done), .cmd_late(cmd_late),
    .late_cnt(late_cnt), .fifo_level(fifo_level)
  );

  adrv9001_rx_sched #(.CMD_DEPTH(4), .TS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_cmd_tdata(tdata8), .s_cmd_tvalid(tvalid8),
    .s_cmd_tready(tready8),
    .sample_ce(sample_ce), .rx_valid(rx_valid),
    .abort(abort),
    .rx_enable(rx_enable8), .rx_last(rx_last8),
    .timestamp(ts8), .busy(busy8),
    .cmd_done(done8), .cmd_late(late8),
    .late_cnt(late_cnt8), .fifo_level(level8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    tvalid    = 1'b0;
    tvalid8   = 1'b0;
    tdata     = '0;
    tdata8    = '0;
    sample_ce = 1'b0;
    rx_valid  = 1'b0;
    abort     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},    64'(rx_enable),  64'd0);
    chk({tag, "_last"},  64'(rx_last),    64'd0);
    chk({tag, "_done"},  64'(cmd_done),   64'd0);
    chk({tag, "_late"},  64'(cmd_late),   64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_ts"},    64'(timestamp),  64'd0);
    chk({tag, "_lcnt"},  64'(late_cnt),   64'd0);
    chk({tag, "_lvl"},   64'(fifo_level), 64'd0);
    chk({tag, "_rdy"},   64'(tready),     64'd1);
  endtask

  int  nv;
  int  n;
  int  dones;
  bit  seen;
  bit  seen2;
  bit  seen3;
  bit  prev;
  int  rises [8];

  initial begin
    do_reset();
    chk_reset("rst0");

    // {100, 8}: enable after ts 100, rx_valid every other cycle
    sample_ce = 1'b1;
    tdata  = {32'd100, 32'd8};
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    chk("t1_busy_n2", 64'(busy), 64'd1);
    for (int i = 0; i < 200; i++) begin
      if (rx_enable) break;
      tick();
    end
    chk("t1_en_seen", 64'(rx_enable), 64'd1);
    chk("t1_en_ts", 64'(timestamp), 64'd101);
    nv = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rx_valid = (i % 2 == 0);
      if (rx_valid) nv++;
      tick();
      if (rx_last) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t1_last_seen", 64'(seen), 64'd1);
    chk("t1_last_nth", 64'(nv), 64'd8);
    chk("t1_en_at_last", 64'(rx_enable), 64'd1);
    rx_valid = 1'b0;
    tick();
    chk("t1_done", 64'(cmd_done), 64'd1);
    chk("t1_en_off", 64'(rx_enable), 64'd0);
    chk("t1_last_off", 64'(rx_last), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);

    // {50, 4} pushed at ts 60: dropped as late
    do_reset();
    sample_ce = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("t2_ts60", 64'(timestamp), 64'd60);
    tdata  = {32'd50, 32'd4};
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    chk("t2_wait", 64'(busy), 64'd1);
    tick();
    chk("t2_late", 64'(cmd_late), 64'd1);
    chk("t2_lcnt", 64'(late_cnt), 64'd1);
    chk("t2_en", 64'(rx_enable), 64'd0);
    tick();
    chk("t2_late_pulse", 64'(cmd_late), 64'd0);
    chk("t2_lcnt_hold", 64'(late_cnt), 64'd1);
    chk("t2_idle", 64'(busy), 64'd0);

    // five back-to-back pushes, sixth refused while full
    do_reset();
    sample_ce = 1'b1;
    rx_valid  = 1'b1;
    tvalid    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tdata = {32'(20 + 10 * k), 32'd2};
      tick();
      if (k == 3) chk("t3_rdy_l3", 64'(tready), 64'd1);
    end
    chk("t3_lvl4", 64'(fifo_level), 64'd4);
    chk("t3_rdy0", 64'(tready), 64'd0);
    tdata = {32'd70, 32'd2};
    tick();
    tvalid = 1'b0;
    chk("t3_lvl4_hold", 64'(fifo_level), 64'd4);
    n = 0;
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      prev = rx_enable;
      tick();
      if (rx_enable && !prev) begin
        if (n < 8) rises[n] = int'(timestamp);
        n++;
      end
      if (cmd_done) dones++;
    end
    chk("t3_n_cmds", 64'(n), 64'd5);
    chk("t3_n_done", 64'(dones), 64'd5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t3_order%0d", k),
          64'(rises[k]), 64'(21 + 10 * k));
    chk("t3_lvl_end", 64'(fifo_level), 64'd0);
    chk("t3_rdy_end", 64'(tready), 64'd1);

    // 8-bit timestamp: push start 5 at ts 0xF0, fires after wrap
    do_reset();
    sample_ce = 1'b1;
    for (int i = 0; i < 240; i++) tick();
    chk("t4_ts_f0", 64'(ts8), 64'hF0);
    tdata8  = {8'h05, 8'h03};
    tvalid8 = 1'b1;
    tick();
    tvalid8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (late8) seen = 1'b1;
      if (rx_enable8) break;
    end
    chk("t4_en_seen", 64'(rx_enable8), 64'd1);
    chk("t4_en_ts", 64'(ts8), 64'd6);
    chk("t4_no_late", 64'(seen), 64'd0);
    chk("t4_lcnt", 64'(late_cnt8), 64'd0);

    // continuous {10, 0} with two queued, abort after 100 cycles
    do_reset();
    sample_ce = 1'b1;
    rx_valid  = 1'b1;
    tvalid    = 1'b1;
    tdata = {32'd10, 32'd0};
    tick();
    tdata = {32'd500, 32'd4};
    tick();
    tdata = {32'd600, 32'd4};
    tick();
    tvalid = 1'b0;
    seen  = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rx_last) seen = 1'b1;
      if (cmd_done) seen2 = 1'b1;
    end
    chk("t5_en_cont", 64'(rx_enable), 64'd1);
    chk("t5_lvl2", 64'(fifo_level), 64'd2);
    chk("t5_no_last", 64'(seen), 64'd0);
    chk("t5_no_done", 64'(seen2), 64'd0);
    abort  = 1'b1;
    tvalid = 1'b1;
    tdata  = {32'd700, 32'd4};
    tick();
    abort  = 1'b0;
    tvalid = 1'b0;
    chk("t5_en_off", 64'(rx_enable), 64'd0);
    chk("t5_lvl0", 64'(fifo_level), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rdy", 64'(tready), 64'd1);
    chk("t5_ts", 64'(timestamp), 64'd104);
    seen  = 1'b0;
    seen2 = 1'b0;
    seen3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_last) seen = 1'b1;
      if (cmd_done) seen2 = 1'b1;
      if (rx_enable || busy) seen3 = 1'b1;
    end
    chk("t5_post_last", 64'(seen), 64'd0);
    chk("t5_post_done", 64'(seen2), 64'd0);
    chk("t5_post_idle", 64'(seen3), 64'd0);

    // reset while ACTIVE with one command queued
    do_reset();
    sample_ce = 1'b1;
    tvalid    = 1'b1;
    tdata = {32'd5, 32'd0};
    tick();
    tdata = {32'd900, 32'd1};
    tick();
    tvalid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rx_enable) break;
      tick();
    end
    chk("t6_active", 64'(rx_enable), 64'd1);
    chk("t6_lvl1", 64'(fifo_level), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset("t6_rst");
    rst = 1'b0;
    sample_ce = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
